// File: rtl/mac_binarize_if.sv
// Handshake bundle between the two-channel MAC, the binarizer and the next-layer buffer.
// 'slave' is the binarizer's view; 'master' is the view of whatever drives it.
interface mac_binarize_if #(
    parameter int ACC_W  = 10,
    parameter int GROUPS = 8
);
    logic [ACC_W-1:0]    mac_out1;
    logic [ACC_W-1:0]    mac_out2;
    logic                mac_done;
    logic [2*GROUPS-1:0] out_data;
    logic                out_valid;
    logic                out_ready;
    logic                ovf;
    logic                ovf_clr;

    modport master (
        output mac_out1, mac_out2, mac_done, out_ready, ovf_clr,
        input  out_data, out_valid, ovf
    );

    modport slave (
        input  mac_out1, mac_out2, mac_done, out_ready, ovf_clr,
        output out_data, out_valid, ovf
    );
endinterface

// File: rtl/mac_binarize.sv
// Binarizes two signed accumulator results per mac_done against per-channel thresholds,
// packs GROUPS events into one word, and offers it downstream with one word of skid storage.
module mac_binarize #(
    parameter int ACC_W  = 10,
    parameter int GROUPS = 8,
    parameter int THR1   = 0,
    parameter int THR2   = 0,
    parameter bit FLIP1  = 1'b0,
    parameter bit FLIP2  = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    mac_binarize_if.slave  bus
);
    localparam int W     = 2 * GROUPS;
    localparam int CNT_W = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    localparam logic signed [ACC_W-1:0] THR1_S = ACC_W'(THR1);
    localparam logic signed [ACC_W-1:0] THR2_S = ACC_W'(THR2);
    localparam logic [CNT_W-1:0]        LAST   = CNT_W'(GROUPS - 1);

    typedef enum logic {
        FILL,
        HOLD
    } state_e;

    state_e           state_q, state_d;
    logic [W-1:0]     pack_q, pack_d;
    logic [W-1:0]     out_data_q, out_data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic             ovf_q, ovf_d;
    logic [W-1:0]     word;
    logic [1:0]       pair;
    logic             pop;

    always_comb begin
        pair[0] = ($signed(bus.mac_out1) >= THR1_S) ^ FLIP1;
        pair[1] = ($signed(bus.mac_out2) >= THR2_S) ^ FLIP2;
        pop     = out_valid_q & bus.out_ready;

        word = pack_q;
        word[{cnt_q, 1'b0} +: 2] = pair;

        state_d     = state_q;
        pack_d      = pack_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q & ~pop;
        ovf_d       = ovf_q & ~bus.ovf_clr;

        case (state_q)
            FILL: begin
                if (bus.mac_done) begin
                    if (cnt_q == LAST) begin
                        cnt_d = '0;
                        if (!out_valid_q || pop) begin
                            out_data_d  = word;
                            out_valid_d = 1'b1;
                            pack_d      = '0;
                        end else begin
                            pack_d  = word;
                            state_d = HOLD;
                        end
                    end else begin
                        pack_d = word;
                        cnt_d  = cnt_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                // cnt is always 0 here, so a same-cycle event becomes event 0 of a fresh word
                if (pop) begin
                    out_data_d  = pack_q;
                    out_valid_d = 1'b1;
                    state_d     = FILL;
                    pack_d      = '0;
                    if (bus.mac_done) begin
                        pack_d[1:0] = pair;
                        cnt_d       = CNT_W'(1);
                    end
                end else if (bus.mac_done) begin
                    ovf_d = 1'b1;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            pack_q      <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pack_q      <= pack_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_mac_binarize.sv
// Bench for mac_binarize: two instances (plain and flipped/raised threshold) share one stimulus
// stream; a word-queue model is compared every cycle, plus hand-computed word checks.
module tb_mac_binarize;
    localparam int G = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] mac_out1, mac_out2;
    logic       mac_done, out_ready, ovf_clr;

    int checks = 0;
    int errors = 0;

    mac_binarize_if #(.ACC_W(10), .GROUPS(G)) ifa ();
    mac_binarize_if #(.ACC_W(10), .GROUPS(G)) ifb ();

    assign ifa.mac_out1  = mac_out1;
    assign ifa.mac_out2  = mac_out2;
    assign ifa.mac_done  = mac_done;
    assign ifa.out_ready = out_ready;
    assign ifa.ovf_clr   = ovf_clr;
    assign ifb.mac_out1  = mac_out1;
    assign ifb.mac_out2  = mac_out2;
    assign ifb.mac_done  = mac_done;
    assign ifb.out_ready = out_ready;
    assign ifb.ovf_clr   = ovf_clr;

    mac_binarize #(.ACC_W(10), .GROUPS(G), .THR1(0), .THR2(-5), .FLIP1(1'b0), .FLIP2(1'b0))
        u_a (.clk(clk), .rst(rst), .bus(ifa));
    mac_binarize #(.ACC_W(10), .GROUPS(G), .THR1(7), .THR2(0), .FLIP1(1'b1), .FLIP2(1'b0))
        u_b (.clk(clk), .rst(rst), .bus(ifb));

    always #5 clk = ~clk;

    // Model: completed words waiting for the consumer (output register + held word)
    int       thr1_t[2]  = '{0, 7};
    int       thr2_t[2]  = '{-5, 0};
    bit       flip1_t[2] = '{1'b0, 1'b1};
    bit       flip2_t[2] = '{1'b0, 1'b0};
    int       m_n[2];
    logic [7:0] m_w[2][2];
    logic [7:0] m_part[2];
    int       m_cnt[2];
    logic [7:0] m_last[2];
    bit       m_ovf[2];

    function automatic bit bit_rule(int acc, int thr, bit flip);
        return (acc >= thr) ^ flip;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit         pop, drop;
        logic [7:0] p;
        int         a1, a2;
        a1 = int'($signed(mac_out1));
        a2 = int'($signed(mac_out2));
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_n[d] = 0; m_part[d] = '0; m_cnt[d] = 0; m_last[d] = '0; m_ovf[d] = 1'b0;
            end else begin
                pop  = (m_n[d] > 0) && out_ready;
                drop = mac_done && (m_n[d] == 2) && !pop;
                if (pop) begin
                    m_last[d] = m_w[d][0];
                    m_w[d][0] = m_w[d][1];
                    m_n[d]--;
                end
                if (mac_done && !drop) begin
                    p = m_part[d];
                    p[2*m_cnt[d]]   = bit_rule(a1, thr1_t[d], flip1_t[d]);
                    p[2*m_cnt[d]+1] = bit_rule(a2, thr2_t[d], flip2_t[d]);
                    m_part[d] = p;
                    m_cnt[d]++;
                    if (m_cnt[d] == G) begin
                        m_w[d][m_n[d]] = m_part[d];
                        m_n[d]++;
                        m_part[d] = '0;
                        m_cnt[d]  = 0;
                    end
                end
                if (drop) m_ovf[d] = 1'b1;
                else if (ovf_clr) m_ovf[d] = 1'b0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        chk("valid_a", 32'(ifa.out_valid), 32'(m_n[0] > 0));
        chk("data_a",  32'(ifa.out_data),  32'((m_n[0] > 0) ? m_w[0][0] : m_last[0]));
        chk("ovf_a",   32'(ifa.ovf),       32'(m_ovf[0]));
        chk("valid_b", 32'(ifb.out_valid), 32'(m_n[1] > 0));
        chk("data_b",  32'(ifb.out_data),  32'((m_n[1] > 0) ? m_w[1][0] : m_last[1]));
        chk("ovf_b",   32'(ifb.ovf),       32'(m_ovf[1]));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ev(int a, int b);
        mac_done = 1'b1;
        mac_out1 = 10'(a);
        mac_out2 = 10'(b);
        tick();
        mac_done = 1'b0;
    endtask

    task automatic idle();
        mac_done = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; mac_done = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
        mac_out1 = '0; mac_out2 = '0;

        // Reset with random inputs
        for (int i = 0; i < 2; i++) begin
            mac_out1 = 10'($urandom); mac_out2 = 10'($urandom);
            mac_done = 1'($urandom); out_ready = 1'($urandom); ovf_clr = 1'($urandom);
            tick();
        end
        chk("rst_data",  32'(ifa.out_data),  32'h0);
        chk("rst_valid", 32'(ifa.out_valid), 32'h0);
        chk("rst_ovf",   32'(ifa.ovf),       32'h0);
        rst = 1'b0; mac_done = 1'b0; ovf_clr = 1'b0; out_ready = 1'b1;
        idle();

        // Basic pack
        ev(3, -6); ev(-2, -5); ev(0, 10);
        chk("basic_early", 32'(ifa.out_valid), 32'h0);
        ev(-512, 511);
        chk("basic_valid", 32'(ifa.out_valid), 32'h1);
        chk("basic_data",  32'(ifa.out_data),  32'hB9);
        idle();
        chk("basic_1cyc",  32'(ifa.out_valid), 32'h0);

        // Backpressure, overflow, then pop with simultaneous event from HOLD
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) ev(1, -100);
        chk("bp_valid", 32'(ifa.out_valid), 32'h1);
        chk("bp_data",  32'(ifa.out_data),  32'h55);
        chk("bp_ovf0",  32'(ifa.ovf),       32'h0);
        ev(1, -100);
        chk("bp_ovf1",  32'(ifa.ovf),       32'h1);
        ovf_clr = 1'b1; idle(); ovf_clr = 1'b0;
        chk("ovf_clr",  32'(ifa.ovf),       32'h0);
        out_ready = 1'b1;
        ev(5, 5);
        chk("pop1_data",  32'(ifa.out_data),  32'h55);
        chk("pop1_valid", 32'(ifa.out_valid), 32'h1);
        chk("pop1_ovf",   32'(ifa.ovf),       32'h0);
        ev(-1, -100);
        chk("pop2_valid", 32'(ifa.out_valid), 32'h0);
        chk("pop2_data",  32'(ifa.out_data),  32'h55);
        ev(-1, -100); ev(-1, -100);
        chk("simul_data",  32'(ifa.out_data),  32'h03);
        chk("simul_data_b", 32'(ifb.out_data), 32'h57);
        idle();

        // Reset mid-fill
        ev(5, 5); ev(5, 5);
        rst = 1'b1; idle(); rst = 1'b0;
        for (int i = 0; i < 4; i++) ev(-1, -100);
        chk("rstmid_valid", 32'(ifa.out_valid), 32'h1);
        chk("rstmid_data",  32'(ifa.out_data),  32'h00);
        chk("rstmid_data_b", 32'(ifb.out_data), 32'h55);
        idle();

        // Threshold edge with flipped channel 1
        ev(7, 0); ev(6, 0); ev(7, 0); ev(6, 0);
        chk("flip_data_b", 32'(ifb.out_data), 32'hEE);
        chk("flip_data_a", 32'(ifa.out_data), 32'hFF);
        idle();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) ev(7, 0);
        chk("hold_ovf_b", 32'(ifb.ovf), 32'h0);
        ovf_clr = 1'b1;
        ev(7, 0);
        chk("setwins_b", 32'(ifb.ovf), 32'h1);
        chk("setwins_a", 32'(ifa.ovf), 32'h1);
        idle();
        chk("clr_b", 32'(ifb.ovf), 32'h0);
        ovf_clr = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) idle();
        chk("drain_valid", 32'(ifa.out_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
